// File: rtl/counter_nbit.sv
// counter_nbit: up/down counter with a programmable terminal value,
// selectable wrap or saturate behaviour at the limits, a combinational
// terminal-count flag and a registered wrap pulse.
//
// Optional feature, selected by defining COUNTER_NBIT_OVF_STICKY_EN:
//   adds ovf_clr (input) and ovf_flag (registered output). ovf_flag
//   captures every wrap/saturation event and holds until it is cleared.
//   When the macro is undefined these ports do not exist.
//
// Parameters:
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  terminal/modulo value (1..2**WIDTH-1). The default of all
//            ones equals 2**WIDTH-1 and stays exact at WIDTH=32.
//   SAT_MODE 0 = wrap at the limits, 1 = hold at the limits
module counter_nbit #(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SAT_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
`ifdef COUNTER_NBIT_OVF_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_flag,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             at_limit;

  // Terminal count follows up_dn directly so a direction change in the
  // same cycle is reflected before the edge.
  assign at_limit = up_dn ? (count == MAX_VAL) : (count == ZERO);
  assign tc       = at_limit;

  // Next-state selection: load beats enable, enable beats hold. A step
  // taken while at the limit either wraps or holds, and flags a wrap event.
  always_comb begin
    count_next = count;
    wrap_next  = 1'b0;
    if (load) begin
      // Clamp out-of-range load values so count never exceeds MAX_VAL.
      count_next = (load_data > MAX_VAL) ? MAX_VAL : load_data;
    end else if (en) begin
      if (at_limit) begin
        wrap_next = 1'b1;
        if (SAT_MODE) begin
          count_next = count;
        end else begin
          count_next = up_dn ? ZERO : MAX_VAL;
        end
      end else begin
        count_next = up_dn ? (count + ONE) : (count - ONE);
      end
    end
  end

  // Counter and wrap pulse registers; reset clears both immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= ZERO;
      wrap  <= 1'b0;
    end else begin
      count <= count_next;
      wrap  <= wrap_next;
    end
  end

`ifdef COUNTER_NBIT_OVF_STICKY_EN
  // Sticky overflow: a new event on the same edge as a clear wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_flag <= 1'b0;
    end else begin
      ovf_flag <= wrap_next | (ovf_flag & ~ovf_clr);
    end
  end
`endif

endmodule

// File: tb/tb_counter_nbit.sv
// Directed testbench for counter_nbit. Two instances share the inputs:
// u_wrap (WIDTH=4, MAX_VAL=9, SAT_MODE=0) and u_sat (SAT_MODE=1).
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_counter_nbit;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [3:0] load_data;
  logic       ovf_clr;
  logic [3:0] count_w;
  logic       tc_w;
  logic       wrap_w;
  logic       ovf_w;
  logic [3:0] count_s;
  logic       tc_s;
  logic       wrap_s;
  logic       ovf_s;

  int total;
  int bad;

  counter_nbit #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b0)) u_wrap (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_data(load_data),
`ifdef COUNTER_NBIT_OVF_STICKY_EN
    .ovf_clr  (ovf_clr),
    .ovf_flag (ovf_w),
`endif
    .count    (count_w),
    .tc       (tc_w),
    .wrap     (wrap_w)
  );

  counter_nbit #(.WIDTH(4), .MAX_VAL(4'd9), .SAT_MODE(1'b1)) u_sat (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_data(load_data),
`ifdef COUNTER_NBIT_OVF_STICKY_EN
    .ovf_clr  (ovf_clr),
    .ovf_flag (ovf_s),
`endif
    .count    (count_s),
    .tc       (tc_s),
    .wrap     (wrap_s)
  );

`ifndef COUNTER_NBIT_OVF_STICKY_EN
  assign ovf_w = 1'b0;
  assign ovf_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] value);
    load = 1'b1; en = 1'b0; load_data = value;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    total++; if (count_w !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count_w); end
    total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b want=0", wrap_w); end
    total++; if (count_s !== 4'd0) begin bad++; $display("FAIL reset_count_sat got=%0d want=0", count_s); end
`ifdef COUNTER_NBIT_OVF_STICKY_EN
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", ovf_w); end
`endif
    tick();
    total++; if (count_w !== 4'd0) begin bad++; $display("FAIL reset_held_count got=%0d want=0", count_w); end
    reset = 1'b0;
    $display("reset: count=%0d wrap=%0b", count_w, wrap_w);
  endtask

  task automatic test_count_up();
    int unsigned exp_w [12];
    int unsigned exp_s [12];
    exp_w = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_s = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
    en = 1'b1; up_dn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      $display("up step %0d: count=%0d wrap=%0b sat_count=%0d sat_wrap=%0b", i, count_w, wrap_w, count_s, wrap_s);
      total++; if (count_w !== 4'(exp_w[i])) begin bad++; $display("FAIL up_count step=%0d got=%0d want=%0d", i, count_w, exp_w[i]); end
      total++; if (wrap_w !== (i == 9)) begin bad++; $display("FAIL up_wrap step=%0d got=%0b want=%0b", i, wrap_w, (i == 9)); end
      total++; if (count_s !== 4'(exp_s[i])) begin bad++; $display("FAIL up_sat_count step=%0d got=%0d want=%0d", i, count_s, exp_s[i]); end
      total++; if (wrap_s !== (i >= 9)) begin bad++; $display("FAIL up_sat_wrap step=%0d got=%0b want=%0b", i, wrap_s, (i >= 9)); end
    end
    en = 1'b0;
  endtask

  task automatic test_count_down();
    int unsigned exp_w [3];
    exp_w = '{9, 8, 7};
    do_load(4'd0);
    total++; if (count_w !== 4'd0) begin bad++; $display("FAIL down_load got=%0d want=0", count_w); end
    en = 1'b1; up_dn = 1'b0;
    #1;
    total++; if (tc_w !== 1'b1) begin bad++; $display("FAIL down_tc_at_zero got=%0b want=1", tc_w); end
    total++; if (tc_s !== 1'b1) begin bad++; $display("FAIL down_tc_sat got=%0b want=1", tc_s); end
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("down step %0d: count=%0d wrap=%0b sat_count=%0d sat_wrap=%0b", i, count_w, wrap_w, count_s, wrap_s);
      total++; if (count_w !== 4'(exp_w[i])) begin bad++; $display("FAIL down_count step=%0d got=%0d want=%0d", i, count_w, exp_w[i]); end
      total++; if (wrap_w !== (i == 0)) begin bad++; $display("FAIL down_wrap step=%0d got=%0b want=%0b", i, wrap_w, (i == 0)); end
      total++; if (count_s !== 4'd0) begin bad++; $display("FAIL down_sat_count step=%0d got=%0d want=0", i, count_s); end
      total++; if (wrap_s !== 1'b1) begin bad++; $display("FAIL down_sat_wrap step=%0d got=%0b want=1", i, wrap_s); end
    end
    total++; if (tc_w !== 1'b0) begin bad++; $display("FAIL down_tc_at_7 got=%0b want=0", tc_w); end
    en = 1'b0;
  endtask

  task automatic test_saturate();
    do_load(4'd9);
    total++; if (count_s !== 4'd9) begin bad++; $display("FAIL sat_load got=%0d want=9", count_s); end
    total++; if (wrap_s !== 1'b0) begin bad++; $display("FAIL sat_load_wrap got=%0b want=0", wrap_s); end
    en = 1'b1; up_dn = 1'b1;
    #1;
    total++; if (tc_s !== 1'b1) begin bad++; $display("FAIL sat_tc got=%0b want=1", tc_s); end
    for (int i = 0; i < 3; i++) begin
      tick();
      $display("sat step %0d: sat_count=%0d sat_wrap=%0b count=%0d wrap=%0b", i, count_s, wrap_s, count_w, wrap_w);
      total++; if (count_s !== 4'd9) begin bad++; $display("FAIL sat_count step=%0d got=%0d want=9", i, count_s); end
      total++; if (wrap_s !== 1'b1) begin bad++; $display("FAIL sat_wrap step=%0d got=%0b want=1", i, wrap_s); end
      total++; if (count_w !== 4'(i)) begin bad++; $display("FAIL sat_ref_count step=%0d got=%0d want=%0d", i, count_w, i); end
    end
    en = 1'b0;
  endtask

  task automatic test_load_clamp();
    do_load(4'd9);
    load = 1'b1; en = 1'b1; up_dn = 1'b1; load_data = 4'hF;
    tick();
    $display("load 0xF: count=%0d wrap=%0b", count_w, wrap_w);
    total++; if (count_w !== 4'd9) begin bad++; $display("FAIL load_clamp got=%0d want=9", count_w); end
    total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL load_clamp_wrap got=%0b want=0", wrap_w); end
    total++; if (wrap_s !== 1'b0) begin bad++; $display("FAIL load_clamp_sat_wrap got=%0b want=0", wrap_s); end
    load_data = 4'd3;
    tick();
    $display("load 3: count=%0d wrap=%0b", count_w, wrap_w);
    total++; if (count_w !== 4'd3) begin bad++; $display("FAIL load_3 got=%0d want=3", count_w); end
    total++; if (count_s !== 4'd3) begin bad++; $display("FAIL load_3_sat got=%0d want=3", count_s); end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold();
    do_load(4'd9);
    en = 1'b1; up_dn = 1'b1;
    tick();
    total++; if (wrap_w !== 1'b1) begin bad++; $display("FAIL hold_pre_wrap got=%0b want=1", wrap_w); end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      up_dn = ~up_dn;
      tick();
      $display("hold %0d: count=%0d wrap=%0b sat_count=%0d", i, count_w, wrap_w, count_s);
      total++; if (count_w !== 4'd0) begin bad++; $display("FAIL hold_count step=%0d got=%0d want=0", i, count_w); end
      total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL hold_wrap step=%0d got=%0b want=0", i, wrap_w); end
      total++; if (count_s !== 4'd9) begin bad++; $display("FAIL hold_sat_count step=%0d got=%0d want=9", i, count_s); end
    end
  endtask

  task automatic test_back_to_back();
    int unsigned exp_c [4];
    exp_c = '{4, 3, 4, 3};
    do_load(4'd3);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      up_dn = (i % 2 == 0);
      tick();
      $display("b2b step %0d: up_dn=%0b count=%0d", i, up_dn, count_w);
      total++; if (count_w !== 4'(exp_c[i])) begin bad++; $display("FAIL b2b_count step=%0d got=%0d want=%0d", i, count_w, exp_c[i]); end
      total++; if (count_s !== 4'(exp_c[i])) begin bad++; $display("FAIL b2b_sat_count step=%0d got=%0d want=%0d", i, count_s, exp_c[i]); end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(4'd5);
    total++; if (count_w !== 4'd5) begin bad++; $display("FAIL areset_pre got=%0d want=5", count_w); end
    en = 1'b1; up_dn = 1'b1;
    #2 reset = 1'b1;
    #1;
    $display("async reset mid-cycle: count=%0d wrap=%0b", count_w, wrap_w);
    total++; if (count_w !== 4'd0) begin bad++; $display("FAIL areset_count got=%0d want=0", count_w); end
    total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL areset_wrap got=%0b want=0", wrap_w); end
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      $display("resume %0d: count=%0d", i, count_w);
      total++; if (count_w !== 4'(i)) begin bad++; $display("FAIL areset_resume step=%0d got=%0d want=%0d", i, count_w, i); end
    end
    // Reset while a wrap pulse is showing must clear it without an edge.
    en = 1'b0;
    do_load(4'd9);
    en = 1'b1;
    tick();
    total++; if (wrap_w !== 1'b1) begin bad++; $display("FAIL areset_wrap_pre got=%0b want=1", wrap_w); end
    en = 1'b0;
    #2 reset = 1'b1;
    #1;
    $display("async reset on wrap: count=%0d wrap=%0b sat_count=%0d", count_w, wrap_w, count_s);
    total++; if (wrap_w !== 1'b0) begin bad++; $display("FAIL areset_wrap_clr got=%0b want=0", wrap_w); end
    total++; if (count_s !== 4'd0) begin bad++; $display("FAIL areset_sat_count got=%0d want=0", count_s); end
    reset = 1'b0;
    tick();
  endtask

`ifdef COUNTER_NBIT_OVF_STICKY_EN
  task automatic test_ovf();
    do_load(4'd9);
    en = 1'b1; up_dn = 1'b1;
    tick();
    en = 1'b0;
    total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b want=1", ovf_w); end
    tick();
    tick();
    $display("ovf after hold: ovf=%0b", ovf_w);
    total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL ovf_held got=%0b want=1", ovf_w); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    $display("ovf after clear: ovf=%0b", ovf_w);
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b want=0", ovf_w); end
    do_load(4'd9);
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL ovf_load got=%0b want=0", ovf_w); end
    en = 1'b1; ovf_clr = 1'b1;
    tick();
    en = 1'b0; ovf_clr = 1'b0;
    $display("ovf set+clear: ovf=%0b wrap=%0b", ovf_w, wrap_w);
    total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%0b want=1", ovf_w); end
    #2 reset = 1'b1;
    #1;
    total++; if (ovf_w !== 1'b0) begin bad++; $display("FAIL ovf_reset got=%0b want=0", ovf_w); end
    reset = 1'b0;
    tick();
  endtask
`endif

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_data = 4'd0; ovf_clr = 1'b0;
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_load_clamp();
    test_hold();
    test_back_to_back();
    test_async_reset();
`ifdef COUNTER_NBIT_OVF_STICKY_EN
    test_ovf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
